// File: rtl/fp_addsub_rr_scheduler_pkg.sv
// Shared FP definitions and scheduler types for the shared add/sub datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef FP_DEFINES_SVH
`define FP_DEFINES_SVH
`define DWIDTH   16
`define EXPONENT 5
`define MANTISSA 10
`endif

package fp_addsub_rr_scheduler_pkg;

    localparam int DWIDTH   = `DWIDTH;
    localparam int EXPONENT = `EXPONENT;
    localparam int MANTISSA = `MANTISSA;

    // Datapath Ctrl encoding
    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_SUB = 1'b1;

    typedef logic [DWIDTH-1:0] fp_word_t;

    // One issued operation as presented to the datapath
    typedef struct packed {
        fp_word_t a;
        fp_word_t b;
        logic     ctrl;
    } fp_issue_t;

endpackage

// File: rtl/fp_addsub_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr (mod NREQ) wins.
// Latency: purely combinational.
// Backpressure: none; caller masks req to suppress grants.
import fp_addsub_rr_scheduler_pkg::*;

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld,
    output logic [IDW-1:0]  nxt_ptr
);

    localparam int SW = IDW + 1;

    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;

    // Walk candidates ptr, ptr+1, ... wrapping at NREQ; keep the first hit
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        nxt_ptr = ptr;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                nxt_ptr  = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_rr_scheduler.sv
// Shares one pipelined FP add/sub datapath among NREQ requesters, round-robin, one op/cycle.
// Latency: gnt -> res_valid is LAT+2 cycles; results return in issue order.
// Backpressure: none from the datapath; hold stops new grants while in-flight ops drain.
import fp_addsub_rr_scheduler_pkg::*;

module fp_addsub_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] a_in,
    input  logic [NREQ*DWIDTH-1:0] b_in,
    input  logic [NREQ-1:0]        op_in,
    input  logic                   hold,
    output logic [NREQ-1:0]        gnt,
    output logic [DWIDTH-1:0]      fp_a,
    output logic [DWIDTH-1:0]      fp_b,
    output logic                   fp_ctrl,
    output logic                   fp_in_valid,
    input  logic [DWIDTH-1:0]      fp_z,
    input  logic                   fp_eof,
    output logic                   res_valid,
    output logic [IDW-1:0]         res_id,
    output logic [DWIDTH-1:0]      res_z,
    output logic                   res_eof,
    output logic                   eof_sticky,
    input  logic                   eof_clr,
    output logic                   busy
);

    logic [NREQ-1:0] req_eff;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  nxt_ptr;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;

    fp_issue_t       iss_q;
    fp_issue_t       iss_d;
    logic [IDW-1:0]  iss_id;

    logic [LAT-1:0]  tag_vld;
    logic [IDW-1:0]  tag_id [LAT];

    // No grants while held or while reset is applied
    assign req_eff = (hold || !rst_n) ? '0 : req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_eff),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .nxt_ptr (nxt_ptr)
    );

    assign fp_a    = iss_q.a;
    assign fp_b    = iss_q.b;
    assign fp_ctrl = iss_q.ctrl;

    // Select the granted requester's operands; keep the previous ones when idle
    always_comb begin
        iss_d = iss_q;
        if (gnt_vld) begin
            iss_d.a    = a_in[int'(gnt_id)*DWIDTH +: DWIDTH];
            iss_d.b    = b_in[int'(gnt_id)*DWIDTH +: DWIDTH];
            iss_d.ctrl = op_in[gnt_id];
        end
    end

    // Round-robin pointer and issue register feeding the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            iss_q       <= '0;
            iss_id      <= '0;
            fp_in_valid <= 1'b0;
        end else begin
            if (gnt_vld) begin
                ptr    <= nxt_ptr;
                iss_id <= gnt_id;
            end
            iss_q       <= iss_d;
            fp_in_valid <= gnt_vld;
        end
    end

    // Tag pipeline: entry LAT-1 owns the fp_z/fp_eof currently on the datapath outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= fp_in_valid;
            tag_id[0]  <= iss_id;
            for (int k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Return register; value fields only move when a tagged result arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_z     <= '0;
            res_eof   <= 1'b0;
        end else begin
            res_valid <= tag_vld[LAT-1];
            if (tag_vld[LAT-1]) begin
                res_id  <= tag_id[LAT-1];
                res_z   <= fp_z;
                res_eof <= fp_eof;
            end
        end
    end

    // Sticky overflow flag; a new overflow result beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eof_sticky <= 1'b0;
        end else begin
            eof_sticky <= (res_valid & res_eof) | (eof_sticky & ~eof_clr);
        end
    end

    assign busy = fp_in_valid | (|tag_vld) | res_valid;

endmodule
